// File: rtl/aemb_dwb_resp_if.sv
// rtl/aemb_dwb_resp_if.sv - Wishbone-classic data-bus signal bundle for the AEMB dwb port
interface aemb_dwb_resp_if #(
    parameter int AW = 10
);
    logic          dwb_stb_i;
    logic          dwb_wre_i;
    logic [AW-1:0] dwb_adr_i;
    logic [31:0]   dwb_dat_i;
    logic [3:0]    dwb_sel_i;
    logic          dwb_ack_o;
    logic [31:0]   dwb_dat_o;

    modport master (
        output dwb_stb_i, dwb_wre_i, dwb_adr_i, dwb_dat_i, dwb_sel_i,
        input  dwb_ack_o, dwb_dat_o
    );

    modport slave (
        input  dwb_stb_i, dwb_wre_i, dwb_adr_i, dwb_dat_i, dwb_sel_i,
        output dwb_ack_o, dwb_dat_o
    );
endinterface

// File: rtl/aemb_dwb_resp.sv
// rtl/aemb_dwb_resp.sv - data-bus responder with local RAM, byte-lane writes and wait states
module aemb_dwb_resp #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input logic             gclk,
    input logic             grst,
    aemb_dwb_resp_if.slave  dwb
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_TURN = 2'd3;

    // With no wait states the strobe edge in IDLE goes straight to ACK
    localparam bit         NO_WAIT   = (WAIT == 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] mem [0:(1<<AW)-1];
    logic        commit;

    // The edge that enters ACK is the one that commits the transfer
    always_comb begin
        commit = 1'b0;
        if (state == S_IDLE && dwb.dwb_stb_i && NO_WAIT)
            commit = 1'b1;
        else if (state == S_WAIT && dwb.dwb_stb_i && cnt == 4'd0)
            commit = 1'b1;
    end

    // Handshake FSM, wait counter, registered ack and read-data register
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            dwb.dwb_ack_o <= 1'b0;
            dwb.dwb_dat_o <= 32'h0000_0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dwb.dwb_stb_i) begin
                        if (NO_WAIT) begin
                            state         <= S_ACK;
                            dwb.dwb_ack_o <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!dwb.dwb_stb_i) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        state         <= S_ACK;
                        dwb.dwb_ack_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state         <= S_TURN;
                    dwb.dwb_ack_o <= 1'b0;
                end
                default: begin
                    // TURN: strobe deliberately ignored so a held strobe is not re-taken
                    state <= S_IDLE;
                end
            endcase
            if (commit && !dwb.dwb_wre_i)
                dwb.dwb_dat_o <= mem[dwb.dwb_adr_i];
        end
    end

    // RAM write port: no reset term so the array maps onto block/distributed RAM
    always_ff @(posedge gclk) begin
        if (commit && dwb.dwb_wre_i && grst) begin
            for (int b = 0; b < 4; b++) begin
                if (dwb.dwb_sel_i[b])
                    mem[dwb.dwb_adr_i][8*b +: 8] <= dwb.dwb_dat_i[8*b +: 8];
            end
        end
    end
endmodule
